// File: rtl/dec_alu_stage_pkg.sv
// Shared widths and encodings for the decode-to-ALU stage register.
package dec_alu_stage_pkg;

    localparam int unsigned XLEN_DEF    = 32;
    localparam int unsigned REG_AW_DEF  = 5;
    localparam int unsigned ALU_OPW_DEF = 4;
    localparam int unsigned DC_CTLW_DEF = 3;
    localparam int unsigned OPC_W_DEF   = 7;
    localparam int unsigned CNT_W_DEF   = 8;

    // Data-cache control value meaning "no access".
    localparam logic [DC_CTLW_DEF-1:0] DC_CTL_NOP = '0;

    typedef enum logic [ALU_OPW_DEF-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

endpackage

// File: rtl/dec_alu_stage_pipe_skid_slot.sv
// Single pipeline entry: valid bit plus payload, with load and clear.
module pipe_skid_slot #(
    parameter int unsigned W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Clear wins over load; payload is only touched on load.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= i_valid;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/dec_alu_stage.sv
// Decode-to-ALU stage register with valid/ready handshake, one-entry skid
// buffer, flush, bubble gating of side-effect controls and a stall counter.
module dec_alu_stage
    import dec_alu_stage_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned REG_AW  = REG_AW_DEF,
    parameter int unsigned ALU_OPW = ALU_OPW_DEF,
    parameter int unsigned DC_CTLW = DC_CTLW_DEF,
    parameter int unsigned OPC_W   = OPC_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [XLEN-1:0]    in_rs1_data,
    input  logic [XLEN-1:0]    in_rs2_data,
    input  logic [XLEN-1:0]    in_imm,
    input  logic               in_jal_sel,
    input  logic [ALU_OPW-1:0] in_alu_op,
    input  logic               in_wb_en,
    input  logic [DC_CTLW-1:0] in_dc_ctl,
    input  logic               in_csl,
    input  logic [REG_AW-1:0]  in_wb_addr,
    input  logic [REG_AW-1:0]  in_rs1_addr,
    input  logic [REG_AW-1:0]  in_rs2_addr,
    input  logic [OPC_W-1:0]   in_opcode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_op1,
    output logic [XLEN-1:0]    out_op2,
    output logic [XLEN-1:0]    out_imm,
    output logic [ALU_OPW-1:0] out_alu_op,
    output logic               out_wb_en,
    output logic [DC_CTLW-1:0] out_dc_ctl,
    output logic               out_csl,
    output logic [REG_AW-1:0]  out_wb_addr,
    output logic [REG_AW-1:0]  out_rs1_addr,
    output logic [REG_AW-1:0]  out_rs2_addr,
    output logic [OPC_W-1:0]   out_opcode,
    output logic [CNT_W-1:0]   stall_cnt,
    input  logic               stall_cnt_clr
);

    localparam int unsigned PW = 3*XLEN + ALU_OPW + 1 + DC_CTLW + 1 + 3*REG_AW + OPC_W;

    logic          w_m_valid, w_s_valid;
    logic [PW-1:0] w_m_data, w_s_data, w_in_data;
    logic          w_accept, w_m_free;
    logic          w_m_load, w_m_vin, w_s_load, w_s_vin;
    logic [PW-1:0] w_m_din;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [XLEN-1:0]    w_m_op1, w_m_op2, w_m_imm;
    logic [ALU_OPW-1:0] w_m_alu_op;
    logic               w_m_wb_en, w_m_csl;
    logic [DC_CTLW-1:0] w_m_dc_ctl;
    logic [REG_AW-1:0]  w_m_wb_addr, w_m_rs1_addr, w_m_rs2_addr;
    logic [OPC_W-1:0]   w_m_opcode;

    // Jal mux is resolved at capture so the payload carries the final operand.
    assign w_in_data = {(in_jal_sel ? in_pc : in_rs1_data), in_rs2_data, in_imm,
                        in_alu_op, in_wb_en, in_dc_ctl, in_csl,
                        in_wb_addr, in_rs1_addr, in_rs2_addr, in_opcode};

    assign in_ready = !w_s_valid;
    assign w_accept = in_valid && !w_s_valid && !flush;
    assign w_m_free = !w_m_valid || out_ready;

    // Steering: refill M from S first to keep order, otherwise from the input.
    always_comb begin
        w_m_load = 1'b0;
        w_m_vin  = 1'b0;
        w_m_din  = w_in_data;
        w_s_load = 1'b0;
        w_s_vin  = 1'b0;
        if (w_m_free) begin
            w_m_load = 1'b1;
            if (w_s_valid) begin
                w_m_vin  = 1'b1;
                w_m_din  = w_s_data;
                w_s_load = 1'b1;
                w_s_vin  = w_accept;
            end else begin
                w_m_vin  = w_accept;
            end
        end else if (w_accept) begin
            w_s_load = 1'b1;
            w_s_vin  = 1'b1;
        end
    end

    pipe_skid_slot #(.W(PW)) u_main (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_load  (w_m_load),
        .i_clear (flush),
        .i_valid (w_m_vin),
        .i_data  (w_m_din),
        .o_valid (w_m_valid),
        .o_data  (w_m_data)
    );

    pipe_skid_slot #(.W(PW)) u_skid (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_load  (w_s_load),
        .i_clear (flush),
        .i_valid (w_s_vin),
        .i_data  (w_in_data),
        .o_valid (w_s_valid),
        .o_data  (w_s_data)
    );

    assign {w_m_op1, w_m_op2, w_m_imm, w_m_alu_op, w_m_wb_en, w_m_dc_ctl, w_m_csl,
            w_m_wb_addr, w_m_rs1_addr, w_m_rs2_addr, w_m_opcode} = w_m_data;

    assign out_valid    = w_m_valid;
    assign out_op1      = w_m_op1;
    assign out_op2      = w_m_op2;
    assign out_imm      = w_m_imm;
    assign out_alu_op   = w_m_alu_op;
    assign out_wb_en    = w_m_wb_en & w_m_valid;
    assign out_dc_ctl   = w_m_valid ? w_m_dc_ctl : DC_CTLW'(DC_CTL_NOP);
    assign out_csl      = w_m_csl & w_m_valid;
    assign out_wb_addr  = w_m_wb_addr;
    assign out_rs1_addr = w_m_rs1_addr;
    assign out_rs2_addr = w_m_rs2_addr;
    assign out_opcode   = w_m_valid ? w_m_opcode : '0;

    // Saturating count of cycles the held instruction waits on the ALU.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (stall_cnt_clr) begin
            r_stall_cnt <= '0;
        end else if (!flush && w_m_valid && !out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule
